// File: rtl/tiamc1_dl_pkg.sv
// Shared types and address map for the TIA-MC1 download sequencer.
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
package tiamc1_dl_pkg;

  localparam int DL_ADDR_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } dl_state_t;

  typedef enum logic [1:0] {
    SEL_PROG = 2'd0,
    SEL_TILE = 2'd1,
    SEL_SPR  = 2'd2,
    SEL_PROM = 2'd3
  } dl_sel_t;

  localparam logic [DL_ADDR_W-1:0] REG_PROG_BASE = 20'h00000;
  localparam logic [DL_ADDR_W-1:0] REG_TILE_BASE = 20'h0A000;
  localparam logic [DL_ADDR_W-1:0] REG_SPR_BASE  = 20'h12000;
  localparam logic [DL_ADDR_W-1:0] REG_PROM_BASE = 20'h1A000;
  // First address past the colour PROM; anything here or above is not a ROM byte.
  localparam logic [DL_ADDR_W-1:0] DL_LIMIT      = 20'h1A100;

  typedef struct packed {
    dl_sel_t              sel;
    logic [DL_ADDR_W-1:0] offset;
    logic [7:0]           data;
  } dl_entry_t;

  // Pick the highest region whose base is not above addr and rebase into it.
  function automatic dl_entry_t dl_decode(input logic [DL_ADDR_W-1:0] addr,
                                          input logic [7:0]           data);
    dl_entry_t e;
    e.data = data;
    if (addr >= REG_PROM_BASE) begin
      e.sel    = SEL_PROM;
      e.offset = addr - REG_PROM_BASE;
    end else if (addr >= REG_SPR_BASE) begin
      e.sel    = SEL_SPR;
      e.offset = addr - REG_SPR_BASE;
    end else if (addr >= REG_TILE_BASE) begin
      e.sel    = SEL_TILE;
      e.offset = addr - REG_TILE_BASE;
    end else begin
      e.sel    = SEL_PROG;
      e.offset = addr - REG_PROG_BASE;
    end
    return e;
  endfunction

endpackage

// File: rtl/tiamc1_dl_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two (>= 2).
// Latency: a push is visible at pop_dat/empty the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk_sys/reset (sync, active-high); push/push_dat in; pop in; pop_dat (head), full, empty out.
module tiamc1_dl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/tiamc1_dl_ctrl.sv
// Download sequencer: ioctl byte stream -> region-decoded ROM writes, core reset control.
// Latency: a byte written into an idle path presents rom_req the next cycle; 1 byte/cycle with rom_ack high.
// Backpressure: rom_ack low stalls rom_*; FIFO absorbs FIFO_DEPTH more bytes, further bytes are dropped (err_ovf).
// Ports: dl_active/dn_wr/dn_index/dn_addr/dn_data from the HPS; rom_req/rom_ack/rom_sel/rom_addr/rom_data
//        to the memories; core_reset, dl_done, tno, err_ovf, err_range, byte_cnt status.
module tiamc1_dl_ctrl
  import tiamc1_dl_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 1024
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dn_wr,
  input  logic [7:0]        dn_index,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  output logic              rom_req,
  input  logic              rom_ack,
  output logic [1:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              core_reset,
  output logic              dl_done,
  output logic [7:0]        tno,
  output logic              err_ovf,
  output logic              err_range,
  output logic [ADDR_W-1:0] byte_cnt
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  dl_state_t  state;
  logic [HW-1:0] hold_cnt;

  dl_entry_t  in_ent;
  dl_entry_t  fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       fifo_push;
  logic       rom_wr;
  logic       push_req;
  logic       out_free;
  logic       bypass;
  logic       push_acc;
  logic       push_drop;

  assign in_ent   = dl_decode(DL_ADDR_W'(dn_addr), dn_data);
  assign rom_wr   = dn_wr && (dn_index == 8'd0) && (state == ST_LOAD);
  assign push_req = rom_wr && (dn_addr < ADDR_W'(DL_LIMIT));

  // Output register can take a new entry when empty or being acked this cycle.
  assign out_free  = !rom_req || rom_ack;
  assign fifo_pop  = out_free && !fifo_empty;
  // With nothing queued, the incoming byte goes straight to the output register,
  // which keeps ordering and gives the one-cycle write-to-request latency.
  assign bypass    = push_req && out_free && fifo_empty;
  assign fifo_push = push_req && !bypass;
  assign push_acc  = bypass || (fifo_push && (!fifo_full || fifo_pop));
  assign push_drop = fifo_push && fifo_full && !fifo_pop;

  tiamc1_dl_fifo #(
    .WIDTH ($bits(dl_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (in_ent),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // FSM with registered core_reset/dl_done and the per-load status it owns.
  // Pushes only happen in LOAD and the clears only on entry to LOAD, so they never collide.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      dl_done    <= 1'b0;
      err_ovf    <= 1'b0;
      err_range  <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_RUN: begin
          if (dl_active) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            err_ovf    <= 1'b0;
            err_range  <= 1'b0;
            byte_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (!dl_active) state <= ST_DRAIN;
        end
        ST_DRAIN, ST_HOLD: begin
          if (dl_active) begin
            state     <= ST_LOAD;
            hold_cnt  <= '0;
            err_ovf   <= 1'b0;
            err_range <= 1'b0;
            byte_cnt  <= '0;
          end else if (state == ST_DRAIN) begin
            if (fifo_empty && !rom_req) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end else if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            dl_done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (rom_wr && !push_req) err_range <= 1'b1;
      if (push_drop)           err_ovf   <= 1'b1;
      if (push_acc && (byte_cnt != '1)) byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Output register and title latch.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_req  <= 1'b0;
      rom_sel  <= '0;
      rom_addr <= '0;
      rom_data <= '0;
      tno      <= '0;
    end else begin
      if (fifo_pop) begin
        rom_req  <= 1'b1;
        rom_sel  <= fifo_head.sel;
        rom_addr <= ADDR_W'(fifo_head.offset);
        rom_data <= fifo_head.data;
      end else if (bypass) begin
        rom_req  <= 1'b1;
        rom_sel  <= in_ent.sel;
        rom_addr <= ADDR_W'(in_ent.offset);
        rom_data <= in_ent.data;
      end else if (rom_req && rom_ack) begin
        rom_req <= 1'b0;
      end

      if (dn_wr && (dn_index == 8'd1) && (dn_addr == '0)) tno <= dn_data;
    end
  end

endmodule

// File: tb/tb_tiamc1_dl_ctrl.sv
// Directed bench for tiamc1_dl_ctrl with a scoreboard-checked write stream.
// Latency: n/a. Backpressure: drives rom_ack low to stall the output.
module tb_tiamc1_dl_ctrl;

  localparam int HOLD = 32;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dn_wr;
  logic [7:0]  dn_index;
  logic [19:0] dn_addr;
  logic [7:0]  dn_data;
  logic        rom_req;
  logic        rom_ack;
  logic [1:0]  rom_sel;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic        dl_done;
  logic [7:0]  tno;
  logic        err_ovf;
  logic        err_range;
  logic [19:0] byte_cnt;

  always #5 clk_sys = ~clk_sys;

  tiamc1_dl_ctrl #(
    .ADDR_W     (20),
    .FIFO_DEPTH (4),
    .HOLD_CYC   (HOLD)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dl_active  (dl_active),
    .dn_wr      (dn_wr),
    .dn_index   (dn_index),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .core_reset (core_reset),
    .dl_done    (dl_done),
    .tno        (tno),
    .err_ovf    (err_ovf),
    .err_range  (err_range),
    .byte_cnt   (byte_cnt)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [19:0] off;
    logic [7:0]  dat;
    int          at;   // expected monitor cycle, -1 = don't care
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge; a handshake completes when req and ack are both high.
  initial begin
    logic        stall_seen;
    logic [29:0] stall_val;
    exp_t        e;
    stall_seen = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen && rom_req) chk("stable_while_stalled", {rom_sel, rom_addr, rom_data}, stall_val);
        if (rom_req && rom_ack) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: sel=%0d addr=%0h data=%0h with nothing expected", rom_sel, rom_addr, rom_data);
          end else begin
            e = sb.pop_front();
            chk("wr_sel", {30'd0, rom_sel}, {30'd0, e.sel});
            chk("wr_addr", {12'd0, rom_addr}, {12'd0, e.off});
            chk("wr_data", {24'd0, rom_data}, {24'd0, e.dat});
            if (e.at >= 0) chk("wr_latency", cyc, e.at);
          end
          stall_seen = 1'b0;
        end else if (rom_req) begin
          stall_seen = 1'b1;
          stall_val  = {rom_sel, rom_addr, rom_data};
        end else begin
          stall_seen = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [19:0] addr, input logic [7:0] dat);
    dn_wr    = 1'b1;
    dn_index = idx;
    dn_addr  = addr;
    dn_data  = dat;
    tick();
    dn_wr    = 1'b0;
  endtask

  // Index-0 write that must appear on rom_* with the given hand-decoded region/offset.
  task automatic wr_rom(input logic [19:0] addr, input logic [7:0] dat,
                        input logic [1:0] sel, input logic [19:0] off, input logic timed);
    exp_t e;
    e.sel = sel;
    e.off = off;
    e.dat = dat;
    e.at  = timed ? cyc + 1 : -1;
    sb.push_back(e);
    wr(8'd0, addr, dat);
  endtask

  initial begin
    int c0;
    int fall_cyc;
    logic cr_low;

    reset     = 1'b1;
    dl_active = 1'b0;
    dn_wr     = 1'b0;
    dn_index  = 8'd0;
    dn_addr   = '0;
    dn_data   = '0;
    rom_ack   = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset and idle
    tick(100);
    chk("idle_core_reset", {31'd0, core_reset}, 32'd1);
    chk("idle_dl_done",    {31'd0, dl_done},    32'd0);
    chk("idle_rom_req",    {31'd0, rom_req},    32'd0);
    chk("idle_tno",        {24'd0, tno},        32'd0);
    chk("idle_errs",       {30'd0, err_ovf, err_range}, 32'd0);
    chk("idle_byte_cnt",   {12'd0, byte_cnt},   32'd0);

    // Full load, ack tied high
    dl_active = 1'b1;
    tick(2);
    wr_rom(20'h00000, 8'h11, 2'd0, 20'h00000, 1'b1);
    wr_rom(20'h0A005, 8'h22, 2'd1, 20'h00005, 1'b1);
    wr_rom(20'h1A0FF, 8'h33, 2'd3, 20'h000FF, 1'b1);
    tick(3);
    chk("load_core_reset", {31'd0, core_reset}, 32'd1);
    dl_active = 1'b0;
    c0 = cyc;
    fall_cyc = -1;
    for (int i = 0; i < HOLD + 20; i++) begin
      tick();
      if (!core_reset) begin
        fall_cyc = cyc;
        break;
      end
    end
    chk("core_reset_fall_cycle", fall_cyc, c0 + 2 + HOLD);
    chk("run_dl_done",  {31'd0, dl_done},  32'd1);
    chk("run_byte_cnt", {12'd0, byte_cnt}, 32'd3);
    chk("run_sb_empty", sb.size(), 32'd0);

    // Backpressure: 6 back-to-back bytes into a stalled output
    dl_active = 1'b1;
    tick(2);
    chk("reload_core_reset", {31'd0, core_reset}, 32'd1);
    chk("reload_dl_done",    {31'd0, dl_done},    32'd0);
    chk("reload_byte_cnt",   {12'd0, byte_cnt},   32'd0);
    rom_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) wr_rom(20'h00010 + 20'(i), 8'hA0 + 8'(i), 2'd0, 20'h00010 + 20'(i), 1'b0);
      else       wr(8'd0, 20'h00010 + 20'(i), 8'hA0 + 8'(i));
    end
    tick(14);
    chk("bp_err_ovf",  {31'd0, err_ovf},  32'd1);
    chk("bp_byte_cnt", {12'd0, byte_cnt}, 32'd5);
    chk("bp_rom_req",  {31'd0, rom_req},  32'd1);
    chk("bp_head",     {rom_sel, rom_addr, rom_data}, {2'd0, 2'd0, 20'h00010, 8'hA0});
    rom_ack = 1'b1;
    tick(8);
    chk("bp_sb_empty", sb.size(), 32'd0);
    chk("bp_req_idle", {31'd0, rom_req}, 32'd0);

    // Range limit and title number
    wr(8'd0, 20'h1A100, 8'h55);
    tick(3);
    chk("range_err",       {31'd0, err_range}, 32'd1);
    chk("range_byte_cnt",  {12'd0, byte_cnt},  32'd5);
    chk("range_ovf_sticky",{31'd0, err_ovf},   32'd1);
    wr(8'd1, 20'h00000, 8'h07);
    tick();
    chk("tno_load", {24'd0, tno}, 32'h07);
    wr(8'd1, 20'h00001, 8'h09);
    wr(8'd2, 20'h00000, 8'h0A);
    tick();
    chk("tno_ignore", {24'd0, tno}, 32'h07);

    // dl_active returns during HOLD
    dl_active = 1'b0;
    tick(10);
    chk("hold_core_reset", {31'd0, core_reset}, 32'd1);
    dl_active = 1'b1;
    cr_low = 1'b0;
    for (int i = 0; i < HOLD + 8; i++) begin
      tick();
      if (!core_reset) cr_low = 1'b1;
    end
    chk("rehold_core_reset_kept", {31'd0, cr_low}, 32'd0);
    chk("rehold_flags",    {30'd0, err_ovf, err_range}, 32'd0);
    chk("rehold_byte_cnt", {12'd0, byte_cnt}, 32'd0);
    chk("rehold_dl_done",  {31'd0, dl_done},  32'd0);
    wr_rom(20'h12003, 8'h44, 2'd2, 20'h00003, 1'b1);
    tick(2);
    chk("rehold_sb_empty", sb.size(), 32'd0);
    chk("rehold_byte_cnt1", {12'd0, byte_cnt}, 32'd1);

    // Reset while a request is pending
    rom_ack = 1'b0;
    wr_rom(20'h00020, 8'hB0, 2'd0, 20'h00020, 1'b0);
    wr_rom(20'h00021, 8'hB1, 2'd0, 20'h00021, 1'b0);
    tick(2);
    chk("pre_reset_req", {31'd0, rom_req}, 32'd1);
    reset     = 1'b1;
    dl_active = 1'b0;
    sb.delete();
    tick();
    chk("rst_rom_req",    {31'd0, rom_req},    32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_byte_cnt",   {12'd0, byte_cnt},   32'd0);
    chk("rst_tno",        {24'd0, tno},        32'd0);
    reset   = 1'b0;
    rom_ack = 1'b1;
    tick(2 * HOLD + 10);
    chk("post_rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("post_rst_rom_req",    {31'd0, rom_req},    32'd0);
    chk("post_rst_dl_done",    {31'd0, dl_done},    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tiamc1_dl_ctrl.md
Name: tiamc1_dl_ctrl

Overview:
Download sequencer between the HPS ioctl stream and the TIA-MC1 core's ROM/graphics memories.
- Buffers incoming bytes in a small FIFO and decodes each address into a target region with a region-local offset.
- Hands bytes to the memories over a valid/ack handshake.
- Holds the core in reset while loading and for a stretch afterwards, then releases it.
- Also latches the title number from index 1 and reports load status and errors.

Parameters:
- ADDR_W, 20: download address width.
- FIFO_DEPTH, 4: byte buffer entries; power of 2, minimum 2.
- HOLD_CYC, 1024: core_reset stretch after the drain completes, in clk_sys cycles; minimum 1.

Ports:
- clk_sys, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high.
- dl_active, in, 1: download in progress (ioctl_download).
- dn_wr, in, 1: single-cycle byte strobe.
- dn_index, in, 8: ioctl index. 0 = ROM set, 1 = title number.
- dn_addr, in, ADDR_W: byte address.
- dn_data, in, 8: byte data.
- rom_req, out, 1: write valid.
- rom_ack, in, 1: target accepted the write this cycle.
- rom_sel, out, 2: target region (0 = program, 1 = tiles, 2 = sprites, 3 = colour PROM).
- rom_addr, out, ADDR_W: offset within the region.
- rom_data, out, 8: byte to write.
- core_reset, out, 1: hold the core in reset.
- dl_done, out, 1: a load has completed.
- tno, out, 8: title number.
- err_ovf, out, 1: sticky, a byte was dropped because the FIFO was full.
- err_range, out, 1: sticky, address at or above DL_LIMIT.
- byte_cnt, out, ADDR_W: bytes accepted into the FIFO in the current load; saturates at all-ones.

Behaviour:
- Reset values: state IDLE, FIFO empty, rom_req=0, rom_sel/rom_addr/rom_data=0, core_reset=1, dl_done=0, tno=0, err flags=0, byte_cnt=0.
- FSM states: IDLE, LOAD, DRAIN, HOLD, RUN.
  - IDLE → LOAD on dl_active=1.
  - LOAD → DRAIN on dl_active=0.
  - DRAIN → HOLD when the FIFO is empty and rom_req=0.
  - HOLD: counts HOLD_CYC cycles → RUN.
  - RUN → LOAD on dl_active=1.
  - If dl_active rises in DRAIN or HOLD, go to LOAD. FIFO contents are kept; the HOLD counter is cleared.
- Entering LOAD clears dl_done, err_ovf, err_range and byte_cnt.
- core_reset=0 only in RUN. dl_done=1 only in RUN.
- Push rules (index 0), LOAD state only:
  - dn_wr with addr < DL_LIMIT pushes {sel, offset, data}.
  - addr ≥ DL_LIMIT is discarded and sets err_range.
  - dn_wr outside LOAD is ignored.
- Region decode: sel = highest region whose base ≤ addr; offset = addr − base.
- Full FIFO: a push while full is dropped and sets err_ovf. Exception: a pop in the same cycle frees a slot, so the push is accepted and the count is unchanged.
- Index 1: dn_wr with dn_addr=0 loads tno. This works in any state. Other index-1 addresses and all other indices are ignored.
- Output handshake:
  - The FIFO head is registered to rom_* outputs.
  - A byte pushed in cycle n can first present rom_req=1 in cycle n+1 (FIFO empty, no request pending).
  - rom_sel/addr/data are held stable while rom_req=1 and rom_ack=0.
  - When rom_ack=1 with rom_req=1, the next entry is presented in the next cycle if one is available; otherwise rom_req=0. Throughput is one byte per cycle with rom_ack tied high.
  - rom_ack while rom_req=0 is ignored.
- byte_cnt increments once per accepted push.
- Reset mid-load: FIFO is flushed, the pending request is abandoned (rom_req=0 next cycle), state returns to IDLE.

Decomposition:
- Package tiamc1_dl_pkg holds:
  - State enum.
  - Region select enum.
  - Region base constants: REG_PROG_BASE=20'h00000, REG_TILE_BASE=20'h0A000, REG_SPR_BASE=20'h12000, REG_PROM_BASE=20'h1A000.
  - DL_LIMIT=20'h1A100.
  - FIFO entry struct {sel, offset, data}.
- One sub-module, tiamc1_dl_fifo: a synchronous FIFO with push/pop/full/empty and simultaneous push+pop.
- FSM, decode and output register stay in the top module.

Test Plan:
- Reset and idle: reset, then 100 idle cycles → core_reset=1, dl_done=0, rom_req=0, tno=0.
- Full load with rom_ack tied 1: write bytes to addr 0x00000, 0x0A005 and 0x1A0FF, then drop dl_active.
  - Writes are seen as (sel 0, off 0), (sel 1, off 5), (sel 3, off 0xFF), each one cycle after its dn_wr.
  - core_reset falls exactly HOLD_CYC cycles after the drain completes; dl_done=1; byte_cnt=3.
- Backpressure: rom_ack=0 for 20 cycles while 6 bytes are written back-to-back.
  - 4 bytes are held in the FIFO and one output register; err_ovf=1.
  - Releasing ack delivers the accepted bytes in order, and rom_* stay stable while stalled.
- Range and title: dn_addr=0x1A100 (index 0) → err_range=1, no rom_req. dn_index=1, addr 0, data 0x07 → tno=0x07.
- Mid-operation events:
  - dl_active re-asserted during HOLD → returns to LOAD, core_reset stays 1, flags cleared.
  - reset asserted while rom_req=1 → rom_req=0 next cycle, FIFO empty, IDLE.
